// File: rtl/chacha_loader_if.sv
// ---------------------------------------------------------------------------
// chacha_loader_if
// Bundles the byte-load bus, block-done pulse, status flags and the state
// word write port of chacha_loader.
//   slave  : the loader itself (takes strobes/bytes, drives flags and writes)
//   master : the upstream agent (drives strobes/bytes/blk_done, sees flags)
// ---------------------------------------------------------------------------
interface chacha_loader_if;
    logic        wr_key;
    logic        wr_nnc;
    logic        wr_ctr;
    logic [7:0]  data_in;
    logic        blk_done;
    logic        busy;
    logic        key_valid;
    logic        nnc_valid;
    logic        ctr_valid;
    logic        ctr_wrap;
    logic        word_we;
    logic [3:0]  word_addr;
    logic [31:0] word_data;

    modport slave (
        input  wr_key, wr_nnc, wr_ctr, data_in, blk_done,
        output busy, key_valid, nnc_valid, ctr_valid, ctr_wrap,
        output word_we, word_addr, word_data
    );

    modport master (
        output wr_key, wr_nnc, wr_ctr, data_in, blk_done,
        input  busy, key_valid, nnc_valid, ctr_valid, ctr_wrap,
        input  word_we, word_addr, word_data
    );
endinterface

// File: rtl/chacha_loader.sv
// ---------------------------------------------------------------------------
// chacha_loader
// Byte-serial loader in front of the ChaCha state array. Key (32 bytes),
// nonce (12 bytes) and counter (4 bytes) arrive one byte per cycle after a
// per-field strobe, are packed little-endian into 32-bit words and written
// to the state array with single-cycle word writes. Also owns the 32-bit
// block counter and advances it on each blk_done from the core.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   bus    : chacha_loader_if.slave (strobes, data_in, blk_done, busy,
//            valid flags, ctr_wrap, word_we/word_addr/word_data)
// ---------------------------------------------------------------------------
module chacha_loader #(
    parameter int unsigned KEY_BASE = 4,
    parameter int unsigned CTR_ADDR = 12,
    parameter int unsigned NNC_BASE = 13
) (
    input  logic            clk,
    input  logic            rst_n,
    chacha_loader_if.slave  bus
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] LOAD_KEY = 2'd1;
    localparam logic [1:0] LOAD_NNC = 2'd2;
    localparam logic [1:0] LOAD_CTR = 2'd3;

    logic [1:0]  state_reg;
    logic [4:0]  byte_idx_reg;
    logic [23:0] acc_reg;        // bytes 0..2 of the word being assembled
    logic [31:0] counter_reg;
    logic        pending_reg;
    logic        key_valid_reg;
    logic        nnc_valid_reg;
    logic        ctr_valid_reg;
    logic        ctr_wrap_reg;
    logic        word_we_reg;
    logic [3:0]  word_addr_reg;
    logic [31:0] word_data_reg;

    logic [3:0]  base_addr;
    logic [4:0]  last_idx;
    logic [31:0] full_word;
    logic        strobe_any;
    logic        do_inc;

    always_comb begin
        base_addr = 4'(KEY_BASE);
        last_idx  = 5'd31;
        case (state_reg)
            LOAD_NNC: begin
                base_addr = 4'(NNC_BASE);
                last_idx  = 5'd11;
            end
            LOAD_CTR: begin
                base_addr = 4'(CTR_ADDR);
                last_idx  = 5'd3;
            end
            default: ;
        endcase
    end

    assign full_word  = {bus.data_in, acc_reg};
    assign strobe_any = bus.wr_key | bus.wr_nnc | bus.wr_ctr;
    // Increments only happen when the word port is otherwise free: idle and
    // no burst starting. Anything else is parked in the one-deep pending flag.
    assign do_inc     = (state_reg == IDLE) && !strobe_any && (bus.blk_done || pending_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            byte_idx_reg  <= '0;
            acc_reg       <= '0;
            counter_reg   <= '0;
            pending_reg   <= 1'b0;
            key_valid_reg <= 1'b0;
            nnc_valid_reg <= 1'b0;
            ctr_valid_reg <= 1'b0;
            ctr_wrap_reg  <= 1'b0;
            word_we_reg   <= 1'b0;
            word_addr_reg <= '0;
            word_data_reg <= '0;
        end else begin
            word_we_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (strobe_any) begin
                        // Strobe cycle carries byte 0 of the burst.
                        acc_reg[7:0] <= bus.data_in;
                        byte_idx_reg <= 5'd1;
                        if (bus.wr_key) begin
                            state_reg     <= LOAD_KEY;
                            key_valid_reg <= 1'b0;
                        end else if (bus.wr_nnc) begin
                            state_reg     <= LOAD_NNC;
                            nnc_valid_reg <= 1'b0;
                        end else begin
                            state_reg     <= LOAD_CTR;
                            ctr_valid_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    case (byte_idx_reg[1:0])
                        2'd0: acc_reg[7:0]   <= bus.data_in;
                        2'd1: acc_reg[15:8]  <= bus.data_in;
                        2'd2: acc_reg[23:16] <= bus.data_in;
                        default: begin
                            word_we_reg   <= 1'b1;
                            word_addr_reg <= base_addr + {1'b0, byte_idx_reg[4:2]};
                            word_data_reg <= full_word;
                        end
                    endcase

                    if (byte_idx_reg == last_idx) begin
                        state_reg    <= IDLE;
                        byte_idx_reg <= '0;
                        case (state_reg)
                            LOAD_KEY: key_valid_reg <= 1'b1;
                            LOAD_NNC: nnc_valid_reg <= 1'b1;
                            default: begin
                                ctr_valid_reg <= 1'b1;
                                counter_reg   <= full_word;
                                ctr_wrap_reg  <= 1'b0;
                            end
                        endcase
                    end else begin
                        byte_idx_reg <= byte_idx_reg + 5'd1;
                    end
                end
            endcase

            if (do_inc) begin
                counter_reg   <= counter_reg + 32'd1;
                word_we_reg   <= 1'b1;
                word_addr_reg <= 4'(CTR_ADDR);
                word_data_reg <= counter_reg + 32'd1;
                pending_reg   <= 1'b0;
                if (counter_reg == 32'hFFFF_FFFF) begin
                    ctr_wrap_reg <= 1'b1;
                end
            end else if (bus.blk_done) begin
                pending_reg <= 1'b1;
            end
        end
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.key_valid = key_valid_reg;
    assign bus.nnc_valid = nnc_valid_reg;
    assign bus.ctr_valid = ctr_valid_reg;
    assign bus.ctr_wrap  = ctr_wrap_reg;
    assign bus.word_we   = word_we_reg;
    assign bus.word_addr = word_addr_reg;
    assign bus.word_data = word_data_reg;

endmodule
